// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared definitions for the branch unit: operation encodings,
//                ALU flag bit positions, FSM state type and the condition
//                evaluation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Operation encodings carried on br_op; 11..15 are illegal.
    localparam logic [3:0] c_OP_B    = 4'd0;
    localparam logic [3:0] c_OP_BZ   = 4'd1;
    localparam logic [3:0] c_OP_BNZ  = 4'd2;
    localparam logic [3:0] c_OP_BCY  = 4'd3;
    localparam logic [3:0] c_OP_BNCY = 4'd4;
    localparam logic [3:0] c_OP_BS   = 4'd5;
    localparam logic [3:0] c_OP_BNS  = 4'd6;
    localparam logic [3:0] c_OP_BV   = 4'd7;
    localparam logic [3:0] c_OP_BNV  = 4'd8;
    localparam logic [3:0] c_OP_CALL = 4'd9;
    localparam logic [3:0] c_OP_RET  = 4'd10;

    // Bit positions inside the 4-bit flag word.
    localparam int c_FLAG_C = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_S = 1;
    localparam int c_FLAG_V = 0;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    // Taken decision for the plain and conditional branches only; call and
    // ret are resolved by the caller because they depend on RAS state.
    function automatic logic cond_taken(input logic [3:0] op, input logic [3:0] flags);
        logic taken;
        taken = 1'b0;
        case (op)
            c_OP_B    : taken = 1'b1;
            c_OP_BZ   : taken =  flags[c_FLAG_Z];
            c_OP_BNZ  : taken = !flags[c_FLAG_Z];
            c_OP_BCY  : taken =  flags[c_FLAG_C];
            c_OP_BNCY : taken = !flags[c_FLAG_C];
            c_OP_BS   : taken =  flags[c_FLAG_S];
            c_OP_BNS  : taken = !flags[c_FLAG_S];
            c_OP_BV   : taken =  flags[c_FLAG_V];
            c_OP_BNV  : taken = !flags[c_FLAG_V];
            default   : taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_ras.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ras
//  Description : Circular return-address stack. A push while full overwrites
//                the oldest entry; a pop while empty changes nothing. Both
//                events raise sticky indicators that clear only on reset.
//  Ports       : clk, rst        - clock / synchronous active-high reset
//                push, push_data - push request and return address
//                pop             - pop request
//                top             - most recently pushed entry
//                empty           - no valid entries
//                ovf, unf        - sticky overflow / underflow
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    localparam int               c_PTR_W     = $clog2(RAS_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH_CNT = (c_PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0]  r_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_sp;       // next write slot; wraps naturally
    logic [c_PTR_W:0]   r_cnt;      // number of valid entries
    logic               r_ovf;
    logic               r_unf;
    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_full;

    assign w_top_idx = r_sp - c_PTR_W'(1);
    assign w_full    = (r_cnt == c_DEPTH_CNT);
    assign empty     = (r_cnt == '0);
    assign top       = r_mem[w_top_idx];
    assign ovf       = r_ovf;
    assign unf       = r_unf;

    // When full, the slot at r_sp holds the oldest entry, so writing there and
    // advancing the pointer is exactly the overwrite-oldest behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (push) begin
            r_mem[r_sp] <= push_data;
            r_sp        <= r_sp + c_PTR_W'(1);
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + (c_PTR_W + 1)'(1);
            end
        end else if (pop) begin
            if (empty) begin
                r_unf <= 1'b1;
            end else begin
                r_sp  <= w_top_idx;
                r_cnt <= r_cnt - (c_PTR_W + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_unit
//  Description : Resolves branch/call/ret instructions against the stored ALU
//                flags (with same-cycle bypass of a flag write), manages the
//                return-address stack and issues a one-cycle registered
//                redirect/flush pulse for every taken branch.
//  Ports       : clk, rst                - clock / synchronous active-high reset
//                flag_we, flag_in        - ALU flag update {C,Z,S,V}
//                br_valid, br_op         - instruction presented and its opcode
//                br_target, pc_next_seq  - target and return address
//                br_ready                - instruction accepted this cycle
//                redirect, redirect_pc   - PC override strobe and new PC
//                flush                   - kill younger fetched instruction
//                flags_q                 - stored flags
//                ras_ovf, ras_unf        - sticky RAS overflow / underflow
//  Revision    : 1.0 - initial release
// ============================================================================
import branch_pkg::*;

module branch_unit #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic [3:0]        flag_in,
    input  logic              br_valid,
    input  logic [3:0]        br_op,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] pc_next_seq,
    output logic              br_ready,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [3:0]        flags_q,
    output logic              ras_ovf,
    output logic              ras_unf
);

    state_t            r_state;
    logic [3:0]        r_flags;
    logic [ADDR_W-1:0] r_redirect_pc;

    logic [3:0]        w_flags_eff;
    logic              w_accept;
    logic              w_taken;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;

    // A flag write in the same cycle as the branch is visible to it.
    assign w_flags_eff = flag_we ? flag_in : r_flags;

    assign br_ready    = (r_state == ST_IDLE);
    assign w_accept    = br_valid && br_ready;
    assign w_push      = w_accept && (br_op == c_OP_CALL);
    assign w_pop       = w_accept && (br_op == c_OP_RET);
    assign w_target    = (br_op == c_OP_RET) ? w_ras_top : br_target;

    always_comb begin
        w_taken = 1'b0;
        case (br_op)
            c_OP_CALL : w_taken = 1'b1;
            c_OP_RET  : w_taken = !w_ras_empty;
            default   : w_taken = cond_taken(br_op, w_flags_eff);
        endcase
    end

    branch_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (pc_next_seq),
        .pop       (w_pop),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_flags       <= 4'b0000;
            r_redirect_pc <= '0;
        end else begin
            if (flag_we) begin
                r_flags <= flag_in;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_taken) begin
                        r_state       <= ST_REDIRECT;
                        r_redirect_pc <= w_target;
                    end
                end
                ST_REDIRECT: r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs come straight from registers: no path from br_valid to redirect.
    assign redirect    = (r_state == ST_REDIRECT);
    assign flush       = (r_state == ST_REDIRECT);
    assign redirect_pc = r_redirect_pc;
    assign flags_q     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_unit
//  Description : Self-checking bench for branch_unit. The driver feeds a
//                behavioural model and queues the expected outputs for the
//                following cycle; a monitor compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

    localparam int c_AW    = 32;
    localparam int c_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flag_we = 1'b0;
    logic [3:0]      flag_in = 4'd0;
    logic            br_valid = 1'b0;
    logic [3:0]      br_op = 4'd0;
    logic [c_AW-1:0] br_target = '0;
    logic [c_AW-1:0] pc_next_seq = '0;
    logic            br_ready;
    logic            redirect;
    logic [c_AW-1:0] redirect_pc;
    logic            flush;
    logic [3:0]      flags_q;
    logic            ras_ovf;
    logic            ras_unf;

    branch_unit #(.ADDR_W(c_AW), .RAS_DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in),
        .br_valid(br_valid), .br_op(br_op), .br_target(br_target),
        .pc_next_seq(pc_next_seq), .br_ready(br_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .flags_q(flags_q),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        logic            redirect;
        logic [c_AW-1:0] pc;
        logic [3:0]      flags;
        logic            ovf;
        logic            unf;
        logic            ready;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- behavioural model ----------------
    logic [c_AW-1:0] m_ras[$];     // back = most recent return address
    logic [3:0]      m_flags = 4'd0;
    logic            m_ovf = 1'b0;
    logic            m_unf = 1'b0;
    logic            m_busy = 1'b0; // a redirect is being shown this cycle
    logic [c_AW-1:0] m_pc = '0;

    function automatic logic cond(input logic [3:0] op, input logic [3:0] f);
        logic c, z, s, v;
        {c, z, s, v} = f;
        case (op)
            4'd0: return 1'b1;
            4'd1: return z;
            4'd2: return !z;
            4'd3: return c;
            4'd4: return !c;
            4'd5: return s;
            4'd6: return !s;
            4'd7: return v;
            4'd8: return !v;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model(input logic r, input logic we, input logic [3:0] fi,
                         input logic v, input logic [3:0] op,
                         input logic [c_AW-1:0] tgt, input logic [c_AW-1:0] seq);
        logic            taken;
        logic [c_AW-1:0] dest;
        exp_t            e;
        taken = 1'b0;
        dest  = tgt;
        if (r) begin
            m_flags = 4'd0; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            m_busy  = 1'b0; m_pc = '0;
        end else begin
            if (v && !m_busy) begin
                if (op == 4'd9) begin
                    if (m_ras.size() == c_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(seq);
                    taken = 1'b1;
                end else if (op == 4'd10) begin
                    if (m_ras.size() == 0) begin
                        m_unf = 1'b1;
                    end else begin
                        dest  = m_ras.pop_back();
                        taken = 1'b1;
                    end
                end else begin
                    taken = cond(op, we ? fi : m_flags);
                end
            end
            if (we) m_flags = fi;
            m_busy = taken;
            if (taken) m_pc = dest;
        end
        e.cyc = cyc + 1; e.redirect = m_busy; e.pc = m_pc; e.flags = m_flags;
        e.ovf = m_ovf; e.unf = m_unf; e.ready = !m_busy;
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic we, input logic [3:0] fi,
                        input logic v, input logic [3:0] op,
                        input logic [c_AW-1:0] tgt, input logic [c_AW-1:0] seq);
        rst = r; flag_we = we; flag_in = fi; br_valid = v; br_op = op;
        br_target = tgt; pc_next_seq = seq;
        model(r, we, fi, v, op, tgt, seq);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, '0, '0);
    endtask

    // ---------------- monitor ----------------
    function automatic void chk(input string name, input logic [c_AW-1:0] act,
                                input logic [c_AW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
        end
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            chk("stale_expectation", 32'(mon_e.cyc), 32'(cyc));
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("redirect",    32'(redirect), 32'(mon_e.redirect));
            chk("flush",       32'(flush),    32'(mon_e.redirect));
            chk("redirect_pc", redirect_pc,   mon_e.pc);
            chk("flags_q",     32'(flags_q),  32'(mon_e.flags));
            chk("ras_ovf",     32'(ras_ovf),  32'(mon_e.ovf));
            chk("ras_unf",     32'(ras_unf),  32'(mon_e.unf));
            chk("br_ready",    32'(br_ready), 32'(mon_e.ready));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] op;
        // reset state
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, '0, '0);
        idle();

        // bz with same-cycle zero-flag write -> redirect to 0x40
        step(1'b0, 1'b1, 4'b0100, 1'b1, 4'd1, 32'h40, 32'h4);
        idle();

        // bnz not taken with Z set, then back-to-back b 0x90
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 32'h80, 32'h4);
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 32'h90, 32'h4);
        idle();

        // five calls with valid held during each redirect, then rets
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, '0, '0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 32'h1000 + 32'(i), 32'(4 * i));
            step(1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 32'h2000, 32'hDEAD);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 4'd10, 32'h3000, '0);
            idle();
        end

        // illegal opcode: no effect
        step(1'b0, 1'b1, 4'b1010, 1'b0, 4'd0, '0, '0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd12, 32'h500, 32'h504);
        idle();

        // reset during REDIRECT overrides flag write and branch
        step(1'b0, 1'b1, 4'b1111, 1'b1, 4'd0, 32'h700, '0);
        step(1'b1, 1'b1, 4'b0110, 1'b1, 4'd9, 32'h800, 32'h804);
        idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'd10;
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) == 0),
                 4'($urandom),
                 ($urandom_range(0, 9) < 7),
                 op,
                 $urandom,
                 $urandom & 32'hFFFF_FFFC);
        end
        idle();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/target width.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port flag_we  input  1  ALU flag write strobe.
REQ-006 SHALL have port flag_in  input  4  new flags {carry[3], zero[2], sign[1], overflow[0]}.
REQ-007 SHALL have port br_valid  input  1  branch/call/ret instruction presented.
REQ-008 SHALL have port br_op  input  4  operation code (see REQ-014).
REQ-009 SHALL have port br_target  input  ADDR_W  branch/call target.
REQ-010 SHALL have port pc_next_seq  input  ADDR_W  sequential PC of the branch (return address).
REQ-011 SHALL have ports br_ready  output  1  branch accepted this cycle; redirect  output  1  PC override strobe; redirect_pc  output  ADDR_W  new PC; flush  output  1  kill younger fetched instruction.
REQ-012 SHALL have ports flags_q  output  4  stored flags; ras_ovf  output  1  sticky push-when-full; ras_unf  output  1  sticky pop-when-empty.

Function
REQ-013 SHALL load flags_q from flag_in on every cycle with flag_we=1; otherwise hold.
REQ-014 SHALL decode br_op: 0 b (always), 1 bz, 2 bnz, 3 bcy, 4 bncy, 5 bs, 6 bns, 7 bv, 8 bnv, 9 call, 10 ret; 11-15 illegal = not taken, no side effects.
REQ-015 SHALL evaluate conditions on effective flags = flag_in when flag_we=1 in the same cycle, else flags_q (same-cycle bypass).
REQ-016 SHALL accept a branch only when br_valid=1 and br_ready=1; br_ready=1 in IDLE, 0 in REDIRECT.
REQ-017 SHALL implement FSM IDLE/REDIRECT: IDLE -> REDIRECT on accepted taken branch; REDIRECT -> IDLE unconditionally after one cycle; not-taken stays IDLE.
REQ-018 SHALL assert redirect=1 and flush=1 for exactly the one REDIRECT cycle, i.e. one cycle after acceptance; redirect_pc registered at acceptance.
REQ-019 SHALL set redirect_pc = br_target for taken b/conditional/call, = popped RAS entry for ret.
REQ-020 SHALL on call push pc_next_seq and always take; when full, overwrite oldest entry (circular) and set ras_ovf.
REQ-021 SHALL on ret with non-empty RAS pop and take; when empty, not take, leave RAS unchanged, set ras_unf.
REQ-022 SHALL ignore br_valid during REDIRECT (no flag-independent side effects, no RAS change); flag writes still apply.
REQ-023 SHALL keep ras_ovf/ras_unf set until reset.

Reset
REQ-024 SHALL on rst=1 at clock edge: FSM=IDLE, flags_q=0, RAS empty, ras_ovf=ras_unf=0, redirect=flush=0, redirect_pc=0; br_ready=1 from the following cycle.
REQ-025 SHALL let reset override everything, including mid-REDIRECT (redirect/flush drop at that edge) and same-cycle flag_we/br_valid.

Structure
REQ-026 SHALL place br_op encodings, flag bit indices and the FSM state enum in shared package branch_pkg.
REQ-027 SHALL implement the return address stack as sub-module branch_ras (push, pop, full, empty, top, overflow-overwrite).
REQ-028 SHALL contain no latches and no combinational path from br_valid to redirect.

Verification
REQ-029 SHALL test: flags_q=0000, flag_we=1 flag_in=0100 same cycle as bz target 0x40 -> next cycle redirect=1, flush=1, redirect_pc=0x40.
REQ-030 SHALL test: flags_q=0100, bnz target 0x80 -> no redirect, br_ready stays 1, back-to-back b 0x90 next cycle -> redirect_pc=0x90 one cycle later.
REQ-031 SHALL test: 5 calls (pc_next_seq 0x4,0x8,0xC,0x10,0x14) with RAS_DEPTH=4 -> ras_ovf=1; 4 rets -> redirect_pc 0x14,0x10,0xC,0x8; 5th ret -> no redirect, ras_unf=1.
REQ-032 SHALL test: br_valid held during REDIRECT cycle -> br_ready=0, branch not accepted, RAS depth unchanged.
REQ-033 SHALL test: rst=1 in REDIRECT cycle -> next cycle redirect=0, flush=0, flags_q=0, ras_ovf=ras_unf=0, br_ready=1.
REQ-034 SHALL test: br_op=12 with br_valid=1 -> no redirect, flags_q and RAS unchanged.
